// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit for the EX stage.
// It computes one shift-add or restoring-division step per cycle on operand
// magnitudes, then applies the sign correction. The result goes into the
// architectural HI/LO registers. `busy` stalls decode while an operation is
// in flight.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             ext_mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Shared ALU encoding: this value selects unsigned, anything else is signed.
  localparam logic ALU_UNSIGNED_EXT = 1'b1;
  localparam int   CW               = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             op_div;     // latched op: 1 = divide
  logic             neg_res;    // product / quotient must be negated
  logic             neg_rem;    // remainder takes the dividend's sign
  logic             div_zero;   // divisor was zero at accept
  logic [WIDTH-1:0] raw_in1;    // unmodified dividend for the divide-by-zero result
  logic [WIDTH-1:0] opb;        // multiplicand or divisor magnitude
  // {acc_hi, acc_lo} is the running product (multiplier shifts out of acc_lo),
  // or the partial remainder plus the dividend/quotient shift register.
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             signed_mode;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Convert the operands on the bus to magnitudes at accept time.
  always_comb begin
    signed_mode = (ext_mode != ALU_UNSIGNED_EXT);
    mag1        = (signed_mode && in1[WIDTH-1]) ? -in1 : in1;
    mag2        = (signed_mode && in2[WIDTH-1]) ? -in2 : in2;
  end

  // Compute one multiply or divide iteration from the current accumulator.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
    add_sum = '0;
    shifted = '0;
    trial   = '0;
    step_hi = acc_hi;
    step_lo = acc_lo;
    if (!op_div) begin
      add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
      step_hi = add_sum[WIDTH:1];
      step_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      shifted = {acc_hi, acc_lo[WIDTH-1]};
      trial   = shifted - {1'b0, opb};
      step_hi = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ~trial[WIDTH]};
    end
  end

  // Apply the sign correction and the divide-by-zero result for the write to HI/LO.
  always_comb begin
    prod   = {acc_hi, acc_lo};
    fix_hi = acc_hi;
    fix_lo = acc_lo;
    if (!op_div) begin
      {fix_hi, fix_lo} = neg_res ? -prod : prod;
    end else if (div_zero) begin
      fix_hi = raw_in1;
      fix_lo = '1;
    end else begin
      fix_lo = neg_res ? -acc_lo : acc_lo;
      fix_hi = neg_rem ? -acc_hi : acc_hi;
    end
  end

  // Control FSM and datapath registers: reset > flush > state progression.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      count    <= '0;
      op_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      raw_in1  <= '0;
      opb      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
    end else if (flush && (state == CALC || state == FIX)) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CALC;
            busy     <= 1'b1;
            count    <= CW'(WIDTH - 1);
            op_div   <= op;
            neg_res  <= signed_mode & (in1[WIDTH-1] ^ in2[WIDTH-1]);
            neg_rem  <= signed_mode & in1[WIDTH-1];
            div_zero <= (in2 == '0);
            raw_in1  <= in1;
            acc_hi   <= '0;
            acc_lo   <= op ? mag1 : mag2;
            opb      <= op ? mag2 : mag1;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (count == '0) state <= FIX;
          else             count <= count - CW'(1);
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit in the EX stage, fed from the same operand bus (`in1`, `in2`, `ext_mode`) as the ALU. It takes over the long-latency MUL/DIV/MOD work, so that path is not built as single-cycle combinational logic. Results go to architectural HI/LO registers, which the writeback mux reads. `busy` drives the decode-stage stall.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  rising-edge clock; sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only while `busy`=0.
- `op`  in  1  operation: 0 = multiply, 1 = divide.
- `ext_mode`  in  1  signedness, using the ALU's `ALU_UNSIGNED_EXT` encoding; any other value means signed.
- `in1`  in  WIDTH  multiplicand or dividend.
- `in2`  in  WIDTH  multiplier or divisor.
- `flush`  in  1  abort the current operation (pipeline exception or branch kill).
- `hi_we`, `lo_we`  in  1 each  direct HI/LO write (MTHI/MTLO).
- `wdata`  in  WIDTH  data for `hi_we`/`lo_we`.
- `busy`  out  1  high in every state other than IDLE.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `hi`, `lo`  out  WIDTH  registered HI and LO.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - `start`=1 latches the operands, op and sign mode, loads the count with WIDTH-1, and goes to CALC.
  - Operands are converted to magnitudes when signed. The unit records the sign of the result and the sign of the dividend.
- CALC runs one iteration per cycle for WIDTH cycles, then goes to FIX.
  - Multiply: shift-add on magnitudes into a 2·WIDTH product.
  - Divide: restoring division; each step is a (WIDTH+1)-bit trial subtract.
- FIX:
  - Signed multiply: negate the 2·WIDTH product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend (truncating division).
  - FIX then writes {HI,LO}. Multiply gives HI = upper half, LO = lower half. Divide gives LO = quotient, HI = remainder. Go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Divide by zero gives LO = all ones and HI = `in1` as latched, raw. No sign correction is applied, and latency is unchanged.
- Signed most-negative / −1 gives LO = 0x80000000 and HI = 0. This is the natural wrap; no trap is raised.
- All arithmetic is modulo 2^WIDTH per half. Negation is two's complement.
- `flush` in CALC or FIX returns to IDLE on the next edge. HI/LO are left unchanged and `done` is not pulsed.
- `flush` in DONE or IDLE has no effect.
- `start` while `busy`=1 is ignored; it is not queued.
- `hi_we`/`lo_we` are honoured only in IDLE and only if `start`=0. If `start` is also high, the start wins and the write is dropped. A write while busy is dropped.
- Priority: `rst` > `flush` > state progression.

## Timing
- Reset: state = IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, internal counters cleared. Reset mid-operation aborts with no result written.
- Let E0 be the edge that accepts `start`.
- `busy` rises in the cycle after E0.
- CALC covers edges E1–E32 (with WIDTH=32). FIX writes HI/LO at E33.
- `done`=1 and the new `hi`/`lo` are visible in the cycle after E33, i.e. 34 cycles after accept.
- `busy` stays high through the DONE cycle and falls after E34. The earliest next accept is E34+1.
- For general WIDTH, latency = WIDTH+2 cycles.
- Direct writes are visible the cycle after the write edge.
- Inputs `in1`, `in2`, `op` and `ext_mode` may change freely after E0.

## Test plan
- Reset: assert `rst` for 2 cycles mid-CALC. Required: `hi`=`lo`=0, `busy`=0, `done`=0, and no later `done`.
- Signed multiply, −3 × 7 (0xFFFFFFFD, 0x00000007). Required: `done` 34 cycles after accept, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- Unsigned multiply, 0xFFFFFFFF × 0xFFFFFFFF. Required: `hi`=0xFFFFFFFE, `lo`=0x00000001. The same operands signed give `hi`=0, `lo`=1.
- Divide:
  - Signed −7 / 2: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - Unsigned 7 / 2: `lo`=3, `hi`=1.
  - Signed 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
  - 5 / 0: `lo`=0xFFFFFFFF, `hi`=5, still 34 cycles.
- Control:
  - `flush` 10 cycles into CALC: IDLE next cycle, `hi`/`lo` keep their prior values, no `done`.
  - `start` pulsed while busy: ignored, exactly one `done`.
  - `hi_we` with `wdata`=0x1234 in IDLE: `hi`=0x1234 next cycle.
  - `hi_we` together with `start`: write dropped.
